// File: rtl/pong_game_controller.sv
// pong_game_controller: serve/play/game-over sequencer owning ball direction, paddles and scores.
// Define PONG_ATTRACT_EN to run a self-playing attract demo while IDLE.
module pong_game_controller #(
  parameter int width        = 20,
  parameter int height       = 10,
  parameter int xBits        = $clog2(width),
  parameter int yBits        = $clog2(height),
  parameter int paddleHeight = 3,
  parameter int serveDelay   = 30,
  parameter int winScore     = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frameTick,
  input  logic                    startButton,
  input  logic                    leftUp,
  input  logic                    leftDown,
  input  logic                    rightUp,
  input  logic                    rightDown,
  input  logic signed [yBits:0]   ballTop,
  input  logic signed [yBits:0]   ballBottom,
  input  logic signed [xBits:0]   ballLeft,
  input  logic signed [xBits:0]   ballRight,
  output logic        [yBits-1:0] leftPaddleTop,
  output logic        [yBits-1:0] rightPaddleTop,
  output logic                    ballStep,
  output logic                    ballCenter,
  output logic                    ballXDir,
  output logic                    ballYDir,
  output logic        [3:0]       leftScore,
  output logic        [3:0]       rightScore,
  output logic        [1:0]       gameState
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  localparam int CW = $clog2(serveDelay + 1);
  localparam logic [yBits-1:0] P_INIT = yBits'((height - paddleHeight) / 2);
  localparam logic [yBits-1:0] P_MAX = yBits'(height - paddleHeight);
  localparam logic signed [yBits:0] Y_MAX = (yBits + 1)'(height - 1);
  localparam logic signed [yBits:0] P_SPAN = (yBits + 1)'(paddleHeight - 1);
  localparam logic signed [xBits:0] X_HIT = (xBits + 1)'(width - 2);
  localparam logic signed [xBits:0] X_MISS = (xBits + 1)'(width - 1);
  localparam logic [3:0] WIN = 4'(winScore);

  state_t r_state, w_state;
  logic [yBits-1:0] r_lpad, w_lpad, r_rpad, w_rpad;
  logic r_xdir, w_xdir, r_ydir, w_ydir, r_step, w_step, r_center, w_center;
  logic r_toggle, w_toggle, r_start_q;
  logic [3:0] r_lscore, w_lscore, r_rscore, w_rscore, w_lscore_inc, w_rscore_inc;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic signed [yBits:0] w_lp, w_rp, w_lp_bot, w_rp_bot;
  logic w_start, w_lhit, w_rhit, w_lmiss, w_rmiss, w_nx, w_ny, w_serve;

  function automatic logic [yBits-1:0] f_move(input logic [yBits-1:0] top, input logic up, input logic dn);
    return (up && !dn) ? ((top == '0) ? top : top - yBits'(1)) :
           (dn && !up) ? ((top == P_MAX) ? top : top + yBits'(1)) : top;
  endfunction

  assign w_start = startButton && !r_start_q;
  assign w_lp = signed'({1'b0, r_lpad});
  assign w_rp = signed'({1'b0, r_rpad});
  assign w_lp_bot = w_lp + P_SPAN;
  assign w_rp_bot = w_rp + P_SPAN;
  // Collision checks use the paddle positions from before this frame's move.
  assign w_lhit = !r_xdir && ballLeft <= 1 && ballBottom >= w_lp && ballTop <= w_lp_bot;
  assign w_rhit = r_xdir && ballRight >= X_HIT && ballBottom >= w_rp && ballTop <= w_rp_bot;
  assign w_lmiss = !r_xdir && !w_lhit && ballLeft <= 0;
  assign w_rmiss = r_xdir && !w_rhit && ballRight >= X_MISS;
  assign w_nx = w_lhit ? 1'b1 : w_rhit ? 1'b0 : r_xdir;
  assign w_ny = (ballTop <= 0 && !r_ydir) ? 1'b1 : (ballBottom >= Y_MAX && r_ydir) ? 1'b0 : r_ydir;
  assign w_lscore_inc = (r_lscore == 4'd15) ? r_lscore : r_lscore + 4'd1;
  assign w_rscore_inc = (r_rscore == 4'd15) ? r_rscore : r_rscore + 4'd1;
  assign w_cnt_inc = r_cnt + CW'(1);
`ifdef PONG_ATTRACT_EN
  localparam logic signed [yBits:0] P_HALF = (yBits + 1)'(paddleHeight / 2);
  logic signed [yBits:0] w_lmid, w_rmid;
  assign w_lmid = w_lp + P_HALF;
  assign w_rmid = w_rp + P_HALF;
`endif

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_lpad    <= P_INIT;
      r_rpad    <= P_INIT;
      r_xdir    <= 1'b1;
      r_ydir    <= 1'b1;
      r_lscore  <= '0;
      r_rscore  <= '0;
      r_step    <= 1'b0;
      r_center  <= 1'b0;
      r_cnt     <= '0;
      r_toggle  <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_lpad    <= w_lpad;
      r_rpad    <= w_rpad;
      r_xdir    <= w_xdir;
      r_ydir    <= w_ydir;
      r_lscore  <= w_lscore;
      r_rscore  <= w_rscore;
      r_step    <= w_step;
      r_center  <= w_center;
      r_cnt     <= w_cnt;
      r_toggle  <= w_toggle;
      r_start_q <= startButton;
    end

  always_comb begin
    w_state  = r_state;
    w_lpad   = r_lpad;
    w_rpad   = r_rpad;
    w_xdir   = r_xdir;
    w_ydir   = r_ydir;
    w_lscore = r_lscore;
    w_rscore = r_rscore;
    w_step   = 1'b0;
    w_center = 1'b0;
    w_cnt    = r_cnt;
    w_toggle = r_toggle;
    w_serve  = 1'b0;
    case (r_state)
      IDLE:
        if (w_start) begin
          w_lscore = '0;
          w_rscore = '0;
          w_xdir   = 1'b1;
          w_state  = SERVE;
          w_serve  = 1'b1;
        end
`ifdef PONG_ATTRACT_EN
        else if (frameTick) begin
          w_lpad = f_move(r_lpad, w_lmid > ballTop, w_lmid < ballTop);
          w_rpad = f_move(r_rpad, w_rmid > ballTop, w_rmid < ballTop);
          if (w_lmiss || w_rmiss) begin
            w_center = 1'b1;
            w_xdir   = w_rmiss;
          end else begin
            w_xdir = w_nx;
            w_ydir = w_ny;
            w_step = 1'b1;
          end
        end
`endif
      SERVE:
        if (frameTick) begin
          w_lpad  = f_move(r_lpad, leftUp, leftDown);
          w_rpad  = f_move(r_rpad, rightUp, rightDown);
          w_cnt   = w_cnt_inc;
          w_state = (w_cnt_inc == CW'(serveDelay)) ? PLAY : SERVE;
        end
      PLAY:
        if (frameTick) begin
          w_lpad = f_move(r_lpad, leftUp, leftDown);
          w_rpad = f_move(r_rpad, rightUp, rightDown);
          if (w_lmiss) begin
            w_rscore = w_rscore_inc;
            w_xdir   = 1'b0;
            w_state  = (w_rscore_inc == WIN) ? OVER : SERVE;
            w_serve  = w_rscore_inc != WIN;
          end else if (w_rmiss) begin
            w_lscore = w_lscore_inc;
            w_xdir   = 1'b1;
            w_state  = (w_lscore_inc == WIN) ? OVER : SERVE;
            w_serve  = w_lscore_inc != WIN;
          end else begin
            w_xdir = w_nx;
            w_ydir = w_ny;
            w_step = 1'b1;
          end
        end
      OVER:
        if (w_start) begin
          w_lscore = '0;
          w_rscore = '0;
          w_state  = SERVE;
          w_serve  = 1'b1;
        end
      default: ;
    endcase
    // Every entry into SERVE re-centres the ball and alternates the serve's vertical direction.
    if (w_serve) begin
      w_center = 1'b1;
      w_cnt    = '0;
      w_ydir   = r_toggle;
      w_toggle = !r_toggle;
    end
  end

  assign leftPaddleTop  = r_lpad;
  assign rightPaddleTop = r_rpad;
  assign ballStep       = r_step;
  assign ballCenter     = r_center;
  assign ballXDir       = r_xdir;
  assign ballYDir       = r_ydir;
  assign leftScore      = r_lscore;
  assign rightScore     = r_rscore;
  assign gameState      = r_state;
endmodule

// File: tb/tb_pong_game_controller.sv
// tb_pong_game_controller: scoreboard bench; stimulus queues hand-computed output snapshots, a monitor compares them.
module tb_pong_game_controller;
  logic clock = 1'b0, reset, frameTick, startButton;
  logic leftUp, leftDown, rightUp, rightDown;
  logic signed [4:0] ballTop, ballBottom;
  logic signed [5:0] ballLeft, ballRight;
  logic [3:0] leftPaddleTop, rightPaddleTop, leftScore, rightScore;
  logic ballStep, ballCenter, ballXDir, ballYDir;
  logic [1:0] gameState;

  pong_game_controller #(.width(20), .height(10), .paddleHeight(3), .serveDelay(2), .winScore(3)) dut (
    .clock(clock), .reset(reset), .frameTick(frameTick), .startButton(startButton),
    .leftUp(leftUp), .leftDown(leftDown), .rightUp(rightUp), .rightDown(rightDown),
    .ballTop(ballTop), .ballBottom(ballBottom), .ballLeft(ballLeft), .ballRight(ballRight),
    .leftPaddleTop(leftPaddleTop), .rightPaddleTop(rightPaddleTop), .ballStep(ballStep),
    .ballCenter(ballCenter), .ballXDir(ballXDir), .ballYDir(ballYDir),
    .leftScore(leftScore), .rightScore(rightScore), .gameState(gameState)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    string       name;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc = 0, total = 0, bad = 0;
  int es, elp, erp, ex, ey, els, ers;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string show(input logic [21:0] v);
    return $sformatf("st=%0d lp=%0d rp=%0d x=%0b y=%0b ls=%0d rs=%0d step=%0b cen=%0b",
                     v[21:20], v[19:16], v[15:12], v[11], v[10], v[9:6], v[5:2], v[1], v[0]);
  endfunction

  always @(negedge clock) begin
    logic [21:0] got;
    got = {gameState, leftPaddleTop, rightPaddleTop, ballXDir, ballYDir, leftScore, rightScore, ballStep, ballCenter};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc != cyc || got !== e.v) begin
        bad++;
        $display("FAIL %s (cycle %0d): got %s, required %s", e.name, cyc, show(got), show(e.v));
      end
    end
  end

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  task automatic frame();
    frameTick = 1'b1;
    clk1();
    frameTick = 1'b0;
  endtask

  task automatic ball(input int t, input int b, input int l, input int r);
    ballTop = 5'(t);
    ballBottom = 5'(b);
    ballLeft = 6'(l);
    ballRight = 6'(r);
  endtask

  task automatic chk(input string n, input logic step, input logic cen);
    exp_t x;
    x.cyc = cyc;
    x.name = n;
    x.v = {2'(es), 4'(elp), 4'(erp), 1'(ex), 1'(ey), 4'(els), 4'(ers), step, cen};
    q.push_back(x);
  endtask

  initial begin
    reset = 1'b0; frameTick = 1'b0; startButton = 1'b0;
    leftUp = 1'b0; leftDown = 1'b0; rightUp = 1'b0; rightDown = 1'b0;
    ball(4, 4, 10, 10);
    es = 0; elp = 3; erp = 3; ex = 1; ey = 1; els = 0; ers = 0;
    clk1(); clk1(); chk("reset", 0, 0);
    reset = 1'b1;
    frame(); chk("idle_tick", 0, 0);
    startButton = 1'b1; clk1(); es = 1; ey = 0; chk("serve_entry", 0, 1);
    startButton = 1'b0; clk1(); chk("center_clear", 0, 0);
    frame(); chk("serve_cnt1", 0, 0);
    frame(); es = 2; chk("to_play", 0, 0);
    frame(); chk("first_step", 1, 0);
    clk1(); chk("step_clear", 0, 0);
    ball(4, 4, 18, 18); frame(); ex = 0; chk("right_bounce", 1, 0);
    ball(4, 4, 1, 1); frame(); ex = 1; chk("left_bounce", 1, 0);
    ball(4, 4, 10, 10); leftUp = 1'b1;
    frame(); elp = 2; chk("left_up1", 1, 0);
    repeat (4) frame();
    elp = 0; chk("left_up_clamp", 1, 0);
    leftDown = 1'b1; frame(); chk("both_hold", 1, 0);
    leftUp = 1'b0; leftDown = 1'b0;
    ball(4, 4, 18, 18); frame(); ex = 0; chk("right_bounce2", 1, 0);
    ball(0, 0, 1, 1); frame(); ex = 1; ey = 1; chk("corner", 1, 0);
    ball(4, 4, 18, 18); frame(); ex = 0; chk("right_bounce3", 1, 0);
    ball(9, 9, 10, 10); frame(); ey = 0; chk("bottom_wall", 1, 0);
    ball(8, 8, 0, 0); frame(); ers = 1; es = 1; ey = 1; chk("miss1", 0, 1);
    ball(4, 4, 10, 10); frame(); frame(); es = 2; chk("serve_play2", 0, 0);
    ball(8, 8, 0, 0); frame(); ers = 2; es = 1; ey = 0; chk("miss2", 0, 1);
    ball(4, 4, 10, 10); frame(); frame(); es = 2; chk("serve_play3", 0, 0);
    ball(8, 8, 0, 0); frame(); ers = 3; es = 3; chk("game_over", 0, 0);
    leftDown = 1'b1; frame(); chk("over_frozen", 0, 0);
    leftDown = 1'b0;
    startButton = 1'b1; clk1(); ers = 0; es = 1; ey = 1; chk("restart", 0, 1);
    startButton = 1'b0; ball(4, 4, 10, 10); rightDown = 1'b1;
    repeat (10) frame();
    erp = 7; es = 2; chk("right_clamp", 1, 0);
    rightDown = 1'b0;
    frame(); reset = 1'b0;
    es = 0; elp = 3; erp = 3; ex = 1; ey = 1; ers = 0; chk("reset_mid", 0, 0);
    clk1(); reset = 1'b1; clk1(); clk1();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pong_game_controller.md
# pong_game_controller

Sequencing controller for the pong datapath. It sits between the screen scanner's per-frame `move` tick and the ball datapath, and owns the ball's direction, the two paddles, the scores and the serve/play/game-over sequence. Each frame it checks the current ball edges against the walls and paddles, updates direction, moves the paddles, and issues exactly one ball step or a re-centre.

## Interface
- `width`, 20: screen width in columns.
- `height`, 10: screen height in rows.
- `xBits`, $clog2(width): x position bits.
- `yBits`, $clog2(height): y position bits.
- `paddleHeight`, 3: paddle length in rows. The left paddle sits in column 0; the right paddle sits in column width-1.
- `serveDelay`, 30: frames spent in SERVE before play starts.
- `winScore`, 7: score that ends the game, 1..15.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: **asynchronous, active-low** reset.
- `frameTick` in 1: one-cycle pulse per frame, driven by the screen's `move`.
- `startButton` in 1: already synchronised, level.
- `leftUp`, `leftDown`, `rightUp`, `rightDown` in 1 each: paddle buttons, synchronised, level.
- `ballTop`, `ballBottom` in signed [yBits:0]: ball row edges.
- `ballLeft`, `ballRight` in signed [xBits:0]: ball column edges.
- `leftPaddleTop`, `rightPaddleTop` out [yBits-1:0]: paddle top rows.
- `ballStep` out 1: one-cycle pulse; the ball moves one cell in (xDir, yDir).
- `ballCenter` out 1: one-cycle pulse; the ball reloads to screen centre.
- `ballXDir` out 1: 1 = right. `ballYDir` out 1: 1 = down.
- `leftScore`, `rightScore` out [3:0].
- `gameState` out [1:0]: IDLE=0, SERVE=1, PLAY=2, OVER=3.

## Operation
- **Reset values:**
  - gameState = IDLE; scores = 0.
  - Both paddle tops = (height-paddleHeight)/2.
  - ballXDir = 1, ballYDir = 1.
  - ballStep = 0, ballCenter = 0; serve counter = 0; yDir toggle = 0.
- **Start button:** the block registers `startButton` and acts on its rising edge (startEdge).
- **IDLE:** no steps. On startEdge: scores cleared, ballXDir = 1, go to SERVE.
- **SERVE:**
  - Entry: ballCenter pulses once, serve counter is cleared.
  - Each frameTick increments the counter. The tick that makes it equal serveDelay moves the FSM to PLAY; no step is issued on that tick.
  - ballYDir takes the stored toggle value, then the toggle inverts.
- **PLAY, per frameTick, using edges and paddles sampled on the tick cycle:**
  - Vertical: if ballTop <= 0 and ballYDir == 0, set ballYDir = 1. If ballBottom >= height-1 and ballYDir == 1, set ballYDir = 0.
  - Left side, when ballXDir == 0:
    - If ballLeft <= 1 and the ball overlaps the left paddle rows (ballBottom >= top and ballTop <= top+paddleHeight-1), set ballXDir = 1.
    - Else if ballLeft <= 0: rightScore++, ballXDir = 0 (serve toward loser), go to SERVE.
  - Right side mirrors the left: thresholds width-2 and width-1, leftScore++, ballXDir = 1.
  - If no point is scored, ballStep pulses using the updated directions.
- **Game end:** a point that brings a score to winScore goes to OVER instead of SERVE.
- **OVER:** no steps, paddles frozen. startEdge clears the scores and goes to SERVE.
- **Paddles:** move in SERVE and PLAY on frameTick, one row per tick.
  - Up only: top-1, clamped at 0.
  - Down only: top+1, clamped at height-paddleHeight.
  - Both buttons or neither: hold.
- **Simultaneous events:**
  - Corner hit: both direction flips happen on the same tick.
  - Point together with a wall flip: the point wins, no step, the wall flip is discarded.
  - Paddle collision uses pre-move paddle positions.
  - startEdge together with frameTick in IDLE: the start wins.
- **Arithmetic:** comparisons are signed, with paddle rows zero-extended to yBits+1. Scores saturate at 15.

## Timing
- frameTick high in cycle T gives registered outputs (dirs, paddles, scores, gameState) valid at T+1. ballStep is high for exactly cycle T+1.
- ballCenter is high in the first cycle gameState == SERVE.
- At most one ballStep per frameTick. A frameTick arriving while ballStep or ballCenter is high is processed normally.
- Reset is asynchronous: asserting it mid-frame forces every output to its reset value immediately. The FSM resumes at the first clock edge after deassertion.

## Configuration
- `PONG_ATTRACT_EN` defined: IDLE runs an attract demo.
  - The ball plays as in PLAY.
  - Each paddle moves one row per frameTick toward the ball, aiming its middle row at ballTop; buttons are ignored.
  - A miss issues ballCenter and continues in IDLE without scoring.
  - startEdge aborts the demo: scores clear, go to SERVE.
- Undefined: IDLE issues no ballStep and paddles hold.

## Test plan
Bench parameters: width=20, height=10, paddleHeight=3, serveDelay=2, winScore=3.
- **Reset:** reset low mid-PLAY → gameState=0, paddles=3, scores=0, xDir=1, yDir=1, ballStep=0 within the same cycle.
- **Start and serve:** startEdge in IDLE → ballCenter pulse next cycle; 2 frameTicks later gameState=2; next tick → ballStep at T+1.
- **Paddle bounce:** PLAY, ballXDir=0, ballLeft=1, ballTop=ballBottom=4, leftPaddleTop=3, tick → ballXDir=1 and ballStep=1 at T+1.
- **Miss and corner:**
  - ballXDir=0, ballLeft=0, ballTop=8, leftPaddleTop=0 → rightScore=1, gameState=1, no ballStep, ballXDir=0.
  - Corner ballTop=0, ballLeft=1 with paddle overlap → both dirs flip.
- **Game over:** rightScore=2, then a left miss → rightScore=3, gameState=3; ticks yield no steps; startEdge → scores 0, gameState=1.
- **Paddle limits:** leftUp held for 5 ticks from top 3 → 0 (clamped); leftUp+leftDown → holds; rightDown held for 10 ticks → 7.
